// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory serving MEM-stage loads/stores with wait states
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_valid,
  output logic              stall,
  output logic              addr_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  logic                w_aligned, w_accept, w_fire, w_misal, w_unused;
  assign w_aligned = req_addr[1:0] == 2'b00;
  assign w_unused  = ^{req_addr[31:ADDR_W+2]};
  // Next state plus the accept/complete/misaligned strobes that steer the datapath.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    w_misal  = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = req_valid & w_aligned;
        w_misal  = req_valid & ~w_aligned;
        w_next   = w_accept ? BUSY : IDLE;
      end
      BUSY: begin
        w_fire = req_valid & (r_cnt == 4'd0);
        w_next = !req_valid ? IDLE : (w_fire ? DONE : BUSY);
      end
      default: w_next = IDLE;
    endcase
  end
  // Outputs are forced low while reset is held so the pipeline sees a quiet memory.
  assign stall     = reset & (w_accept | (r_state == BUSY));
  assign rsp_valid = reset & (w_misal | (r_state == DONE));
  assign addr_err  = reset & w_misal;
  assign rsp_rdata = w_misal ? '0 : r_rdata;
  // State, wait counter, latched request and load-data register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY - 1);
        r_we    <= req_we;
        r_idx   <= req_addr[ADDR_W+1:2];
        r_wdata <= req_wdata;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !r_we) r_rdata <= r_mem[r_idx];
    end
  end
  // Array write happens only on the completing edge of a store; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_fire && r_we) r_mem[r_idx] <= r_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized transaction-level check of dmem_responder against a reference memory model
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata;
  logic        rsp_valid, stall, addr_err;
  logic        s_valid = 1'b0, s_we = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_valid, a_stall, a_err, b_valid, b_stall, b_err;
  int          n_chk = 0, n_err = 0, cyc = 0;
  logic [31:0] model [1024];
  logic [31:0] last_rd = '0;
  always @(posedge clock) cyc <= cyc + 1;
  dmem_responder #(.LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdata(rsp_rdata),
    .rsp_valid(rsp_valid), .stall(stall), .addr_err(addr_err));
  dmem_responder #(.LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .req_valid(s_valid), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata), .rsp_rdata(a_rdata),
    .rsp_valid(a_valid), .stall(a_stall), .addr_err(a_err));
  dmem_responder #(.LATENCY(15)) u_l15 (
    .clock(clock), .reset(reset), .req_valid(s_valid), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata), .rsp_rdata(b_rdata),
    .rsp_valid(b_valid), .stall(b_stall), .addr_err(b_err));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (addr[1:0] != 2'b00) begin
      @(negedge clock);
      check("mis_err", addr_err, 1);
      check("mis_valid", rsp_valid, 1);
      check("mis_rdata", rsp_rdata, 0);
      check("mis_stall", stall, 0);
      @(posedge clock); #1;
    end else begin
      for (int k = 0; k <= LAT; k++) begin
        if (k > 0) begin
          req_addr  = $urandom;
          req_wdata = $urandom;
        end
        @(negedge clock);
        check("busy_stall", stall, 1);
        check("busy_valid", rsp_valid, 0);
        check("busy_err", addr_err, 0);
        @(posedge clock); #1;
      end
      @(negedge clock);
      check("done_valid", rsp_valid, 1);
      check("done_stall", stall, 0);
      if (we) model[idx_of(addr)] = wd;
      else begin
        last_rd = model[idx_of(addr)];
        check("load_data", rsp_rdata, last_rd);
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
  endtask
  task automatic idle();
    req_valid = 1'b0;
    req_addr  = $urandom;
    @(negedge clock);
    check("idle_stall", stall, 0);
    check("idle_valid", rsp_valid, 0);
    check("idle_err", addr_err, 0);
    check("idle_hold", rsp_rdata, last_rd);
    @(posedge clock); #1;
  endtask
  task automatic sweep(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int c1, output int c15, output logic [31:0] d1, output logic [31:0] d15);
    logic f1, f15;
    f1 = 1'b0; f15 = 1'b0; c1 = 0; c15 = 0; d1 = '0; d15 = '0;
    s_valid = 1'b1; s_we = we; s_addr = addr; s_wdata = wd;
    for (int k = 0; k < 40 && !(f1 && f15); k++) begin
      @(negedge clock);
      if (!f1) begin
        if (a_stall) c1++;
        if (a_valid) begin f1 = 1'b1; d1 = a_rdata; end
      end
      if (!f15) begin
        if (b_stall) c15++;
        if (b_valid) begin f15 = 1'b1; d15 = b_rdata; end
      end
      @(posedge clock); #1;
    end
    s_valid = 1'b0;
    check("sweep_done", {30'd0, f1, f15}, 3);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, c1, c15;
    logic [31:0] d1, d15, x;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin
      model[i] = $urandom;
      u_dut.r_mem[i] = model[i];
    end
    req_valid = 1'b1;
    req_addr  = 32'h10;
    #12;
    check("rst_stall", stall, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", addr_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    req_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    model[4] = 32'hDEADBEEF;
    u_dut.r_mem[4] = 32'hDEADBEEF;
    access(1'b0, 32'h10, 32'h0);
    idle();
    c0 = cyc;
    access(1'b1, 32'h20, 32'h12345678);
    access(1'b0, 32'h20, 32'h0);
    check("b2b_cycles", cyc - c0, 8);
    idle();
    access(1'b0, 32'h22, $urandom);
    access(1'b1, 32'h22, $urandom);
    idle();
    access(1'b0, 32'h20, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hAAAA5555;
    @(negedge clock); check("fl_stall0", stall, 1);
    @(posedge clock); #1; req_valid = 1'b0;
    @(negedge clock); check("fl_stall1", stall, 1);
    @(posedge clock); #1;
    idle();
    access(1'b0, 32'h40, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = ~model[2];
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_err", addr_err, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    last_rd = '0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    access(1'b0, 32'h8, 32'h0);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      a = $urandom & 32'hFFFF_F0FC;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      access(1'($urandom_range(0, 1)), a, $urandom);
    end
    x = $urandom;
    sweep(1'b1, 32'h1000, x, c1, c15, d1, d15);
    check("l1_store_stall", c1, 2);
    check("l15_store_stall", c15, 16);
    @(posedge clock); #1;
    sweep(1'b0, 32'h0, 32'h0, c1, c15, d1, d15);
    check("l1_load_stall", c1, 2);
    check("l15_load_stall", c15, 16);
    check("l1_wrap_data", d1, x);
    check("l15_wrap_data", d15, x);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
